// File: rtl/fmc_wr_ram_map.sv
// fmc_wr_ram_map: FSMC write-side register file.
// Synchronizes the async FSMC bus, detects completed
// writes and commits them into NUM_REGS 16-bit regs.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   cs_i/rd_i/wr_i   FSMC strobes, active-low, async
//   addr_i, data_i   FSMC word address / write data
//   arm_fpga_data_o  flattened register file
//   wr_strobe_o      one-hot update pulse per register
//   wr_err_o         pulse: out-of-range or rd/wr clash
//   wr_cnt_o         committed write counter (wraps)
module fmc_wr_ram_map #(
   parameter int unsigned NUM_REGS  = 64,
   parameter logic [24:0] BASE_ADDR = 25'd128,
   parameter logic [15:0] RESET_VAL = 16'h0000
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cs_i,
   input  logic                     rd_i,
   input  logic                     wr_i,
   input  logic [24:0]              addr_i,
   input  logic [15:0]              data_i,
   output logic [NUM_REGS*16-1:0]   arm_fpga_data_o,
   output logic [NUM_REGS-1:0]      wr_strobe_o,
   output logic                     wr_err_o,
   output logic [15:0]              wr_cnt_o
);

   localparam int unsigned IDX_W =
      (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   // 26 bits so BASE_ADDR+NUM_REGS cannot overflow
   localparam logic [25:0] END_ADDR =
      {1'b0, BASE_ADDR} + 26'(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE,
      WR_ACT,
      COMMIT,
      ABORT
   } state_t;

   state_t state_q, state_d;

   logic        cs_s1, cs_s;
   logic        wr_s1, wr_s;
   logic        rd_s1, rd_s;
   logic [24:0] addr_s1, addr_s;
   logic [15:0] data_s1, data_s;

   logic [24:0] cap_addr;
   logic [15:0] cap_data;

   logic [15:0]         regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] wr_strobe_q;
   logic                wr_err_q;
   logic [15:0]         wr_cnt_q;

   logic             cap_en;
   logic             commit;
   logic             abort_go;
   logic             in_range;
   logic             commit_ok;
   logic             commit_err;
   logic [IDX_W-1:0] idx;

   // Two-flop synchronizer; all bus lines share the
   // same depth so address/data align with strobes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cs_s1   <= 1'b1;
         cs_s    <= 1'b1;
         wr_s1   <= 1'b1;
         wr_s    <= 1'b1;
         rd_s1   <= 1'b1;
         rd_s    <= 1'b1;
         addr_s1 <= '0;
         addr_s  <= '0;
         data_s1 <= '0;
         data_s  <= '0;
      end else begin
         cs_s1   <= cs_i;
         cs_s    <= cs_s1;
         wr_s1   <= wr_i;
         wr_s    <= wr_s1;
         rd_s1   <= rd_i;
         rd_s    <= rd_s1;
         addr_s1 <= addr_i;
         addr_s  <= addr_s1;
         data_s1 <= data_i;
         data_s  <= data_s1;
      end
   end

   always_comb begin
      state_d  = state_q;
      cap_en   = 1'b0;
      commit   = 1'b0;
      abort_go = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!cs_s && !wr_s && rd_s)
               state_d = WR_ACT;
         end
         WR_ACT: begin
            // no capture on the release cycle: the
            // last active-cycle value is committed
            if (wr_s || cs_s) begin
               state_d = COMMIT;
            end else begin
               cap_en = 1'b1;
               if (!rd_s) begin
                  state_d  = ABORT;
                  abort_go = 1'b1;
               end
            end
         end
         COMMIT: begin
            state_d = IDLE;
            commit  = 1'b1;
         end
         ABORT: begin
            if (wr_s && cs_s)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_range = (cap_addr >= BASE_ADDR) &&
                     ({1'b0, cap_addr} < END_ADDR);
   assign idx        = IDX_W'(cap_addr - BASE_ADDR);
   assign commit_ok  = commit && in_range;
   assign commit_err = commit && !in_range;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cap_addr    <= '0;
         cap_data    <= '0;
         wr_strobe_q <= '0;
         wr_err_q    <= 1'b0;
         wr_cnt_q    <= '0;
         for (int k = 0; k < NUM_REGS; k++)
            regs_q[k] <= RESET_VAL;
      end else begin
         state_q     <= state_d;
         wr_strobe_q <= '0;
         wr_err_q    <= commit_err || abort_go;
         if (cap_en) begin
            cap_addr <= addr_s;
            cap_data <= data_s;
         end
         if (commit_ok) begin
            regs_q[idx]      <= cap_data;
            wr_strobe_q[idx] <= 1'b1;
            wr_cnt_q         <= wr_cnt_q + 16'd1;
         end
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
      assign arm_fpga_data_o[16*k +: 16] = regs_q[k];
   end

   assign wr_strobe_o = wr_strobe_q;
   assign wr_err_o    = wr_err_q;
   assign wr_cnt_o    = wr_cnt_q;

endmodule

// File: tb/tb_fmc_wr_ram_map.sv
// tb_fmc_wr_ram_map: directed bench with an output
// scoreboard for the FSMC write register map.
module tb_fmc_wr_ram_map;

   localparam int N = 64;
   localparam logic [24:0] BASE = 25'd128;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cs = 1'b1;
   logic          rd = 1'b1;
   logic          wr = 1'b1;
   logic [24:0]   addr = '0;
   logic [15:0]   data = '0;
   logic [N*16-1:0] regs_o;
   logic [N-1:0]  strobe;
   logic          err;
   logic [15:0]   cnt;

   fmc_wr_ram_map #(
      .NUM_REGS (N),
      .BASE_ADDR(BASE),
      .RESET_VAL(16'h0000)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .cs_i           (cs),
      .rd_i           (rd),
      .wr_i           (wr),
      .addr_i         (addr),
      .data_i         (data),
      .arm_fpga_data_o(regs_o),
      .wr_strobe_o    (strobe),
      .wr_err_o       (err),
      .wr_cnt_o       (cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_err;
      int          idx;
      logic [15:0] data;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] model [N];
   logic [15:0] exp_cnt;
   int          passed = 0;
   int          total = 0;
   int          strobes = 0;
   int          s0;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h, expected %0h",
                  tag, obs, exp);
   endtask

   task automatic chk_regs(input string tag);
      for (int k = 0; k < N; k++)
         chk(tag, 64'(regs_o[16*k +: 16]), 64'(model[k]));
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++)
         model[k] = 16'h0000;
      exp_cnt = 16'h0000;
      sb.delete();
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1;
      e.idx    = 0;
      e.data   = 16'h0000;
      e.cnt    = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic push_write(input logic [24:0] a,
                             input logic [15:0] d);
      exp_t e;
      if (a >= BASE && a < BASE + 25'(N)) begin
         exp_cnt = exp_cnt + 16'd1;
         model[int'(a - BASE)] = d;
         e.is_err = 1'b0;
         e.idx    = int'(a - BASE);
         e.data   = d;
         e.cnt    = exp_cnt;
         sb.push_back(e);
      end else begin
         push_err();
      end
   endtask

   // called on a falling edge; returns gap cycles
   // after the wr_i/cs_i rise
   task automatic fmc_write(input logic [24:0] a,
                            input logic [15:0] d,
                            input int low,
                            input int gap);
      push_write(a, d);
      addr = a;
      data = d;
      cs   = 1'b0;
      wr   = 1'b0;
      repeat (low) @(negedge clk);
      wr = 1'b1;
      cs = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cs  = 1'b1;
      wr  = 1'b1;
      rd  = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && (strobe != '0 || err)) begin
         if (strobe != '0)
            strobes++;
         if (sb.size() == 0) begin
            total++;
            $error("FAIL unexpected_out: strobe %0h err %0b, expected none",
                   strobe, err);
         end else begin
            e = sb.pop_front();
            if (e.is_err) begin
               chk("err_strobe", 64'(strobe), 64'd0);
               chk("err_pulse", 64'(err), 64'd1);
               chk("err_cnt", 64'(cnt), 64'(e.cnt));
            end else begin
               chk("wr_strobe", 64'(strobe),
                   64'd1 << e.idx);
               chk("wr_noerr", 64'(err), 64'd0);
               chk("wr_reg", 64'(regs_o[16*e.idx +: 16]),
                   64'(e.data));
               chk("wr_cnt", 64'(cnt), 64'(e.cnt));
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_regs("reset_regs");
      chk("reset_cnt", 64'(cnt), 64'd0);
      chk("reset_strobe", 64'(strobe), 64'd0);
      chk("reset_err", 64'(err), 64'd0);

      fmc_write(25'd130, 16'hA5C3, 5, 0);
      repeat (3) @(negedge clk);
      chk("lat_reg_early", 64'(regs_o[47:32]), 64'd0);
      chk("lat_strobe_early", 64'(strobe), 64'd0);
      @(negedge clk);
      chk("lat_reg", 64'(regs_o[47:32]), 64'hA5C3);
      chk("lat_strobe", 64'(strobe), 64'h4);
      @(negedge clk);
      chk("strobe_1cyc", 64'(strobe), 64'd0);
      chk("single_cnt", 64'(cnt), 64'd1);

      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk_regs("async_reset");
      chk("async_cnt", 64'(cnt), 64'd0);
      chk("async_strobe", 64'(strobe), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      fmc_write(25'd127, 16'h1111, 3, 3);
      fmc_write(25'd128, 16'h2222, 3, 3);
      fmc_write(25'd191, 16'h3333, 3, 3);
      fmc_write(25'd192, 16'h4444, 3, 3);
      repeat (6) @(negedge clk);
      chk_regs("bounds_regs");
      chk("bounds_cnt", 64'(cnt), 64'd2);

      addr = 25'd129;
      cs   = 1'b0;
      rd   = 1'b0;
      repeat (5) @(negedge clk);
      cs = 1'b1;
      rd = 1'b1;
      repeat (5) @(negedge clk);
      chk("read_cnt", 64'(cnt), 64'd2);

      do_reset();
      s0 = strobes;
      for (int k = 0; k < N; k++)
         fmc_write(25'(128 + k), 16'(128 + k), 3, 2);
      repeat (6) @(negedge clk);
      chk_regs("b2b_regs");
      chk("b2b_cnt", 64'(cnt), 64'd64);
      chk("b2b_strobes", 64'(strobes - s0), 64'd64);

      push_err();
      addr = 25'd135;
      data = 16'hDEAD;
      cs   = 1'b0;
      wr   = 1'b0;
      repeat (2) @(negedge clk);
      rd = 1'b0;
      repeat (3) @(negedge clk);
      rd = 1'b1;
      wr = 1'b1;
      cs = 1'b1;
      repeat (6) @(negedge clk);
      chk("conflict_reg7", 64'(regs_o[16*7 +: 16]),
          64'(model[7]));
      chk("conflict_cnt", 64'(cnt), 64'd64);
      fmc_write(25'd135, 16'hBEEF, 3, 3);
      repeat (6) @(negedge clk);
      chk("post_conflict", 64'(regs_o[16*7 +: 16]),
          64'hBEEF);

      addr = 25'd140;
      data = 16'h5A5A;
      cs   = 1'b0;
      wr   = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      cs = 1'b1;
      wr = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("midwr_reg12", 64'(regs_o[16*12 +: 16]), 64'd0);
      chk("midwr_cnt", 64'(cnt), 64'd0);

      @(negedge clk);
      force dut.wr_cnt_q = 16'hFFFE;
      repeat (2) @(negedge clk);
      release dut.wr_cnt_q;
      exp_cnt = 16'hFFFE;
      @(negedge clk);
      chk("preload_cnt", 64'(cnt), 64'hFFFE);
      fmc_write(25'd128, 16'h0001, 3, 3);
      fmc_write(25'd129, 16'h0002, 3, 3);
      repeat (6) @(negedge clk);
      chk("wrap_cnt", 64'(cnt), 64'd0);

      repeat (4) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk_regs("final_regs");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
